// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control FSM.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    // Instruction class field ir[27:26]
    localparam logic [1:0] CLS_DP   = 2'b00;
    localparam logic [1:0] CLS_HALT = 2'b11;

    // Compare-only opcodes: flags written, Rd untouched
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_CMN = 4'hB;

    function automatic logic is_cmp_op(input logic [3:0] op);
        return (op >= OP_TST) && (op <= OP_CMN);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_count;

    // Count up on inc until every bit is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/execute control FSM with retired/skipped counters.
// Strobes are registered so each one is high during the state it belongs to.
// Optional single-step mode: define MULTICYCLE_CTRL_STEP_EN to add the step input.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MULTICYCLE_CTRL_STEP_EN
    input  logic             step,
`endif
    input  logic [31:0]      ir,
    input  logic             w_ir_valid,
    output logic             write_pc,
    output logic             write_ir,
    output logic             read_ops,
    output logic             alu_en,
    output logic [3:0]       alu_op,
    output logic             write_reg,
    output logic             write_nzcv,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] skipped
);

    localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

    state_e     r_state;
    logic [3:0] r_wait;
    logic       r_write_pc, r_write_ir, r_read_ops, r_alu_en;
    logic       r_write_reg, r_write_nzcv, r_halted, r_illegal;
    logic [3:0] r_alu_op;

    logic [1:0] w_cls;
    logic       w_cls_bad;
    logic       w_go;
    logic       w_armed;
    logic       w_fetch_now;
    logic       w_enter_fetch;
    logic       w_ret_inc;
    logic       w_skp_inc;
    logic       w_unused_ir;

    assign w_cls       = ir[27:26];
    assign w_cls_bad   = (w_cls != CLS_DP) && (w_cls != CLS_HALT);
    assign w_unused_ir = ^{ir[31:28], ir[25], ir[19:0]};

    // Strobe in the very first S_FETCH cycle when no wait is configured
    assign w_fetch_now = w_go && (WAIT_LAST == 4'd0);

    assign w_enter_fetch = (r_state == S_IDLE)
                         || ((r_state == S_CHECK) && !w_ir_valid)
                         || ((r_state == S_DECODE) && w_cls_bad)
                         || (r_state == S_WB);

`ifdef MULTICYCLE_CTRL_STEP_EN
    logic r_step_pend;
    logic r_armed;
    logic w_consume;

    assign w_go      = step || r_step_pend;
    assign w_armed   = r_armed;
    assign w_consume = w_enter_fetch || ((r_state == S_FETCH) && !r_armed);

    // 1-deep step latch; armed marks an S_FETCH that already owns a step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_pend <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            if (w_consume) begin
                r_step_pend <= 1'b0;
            end else if (step && (r_state != S_FETCH)) begin
                r_step_pend <= 1'b1;
            end
            if (w_enter_fetch) begin
                r_armed <= w_go;
            end else if ((r_state == S_FETCH) && !r_armed && w_go) begin
                r_armed <= 1'b1;
            end
        end
    end
`else
    assign w_go    = 1'b1;
    assign w_armed = 1'b1;
`endif

    // Main sequencer: state plus the strobes for the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_write_pc   <= 1'b0;
            r_write_ir   <= 1'b0;
            r_read_ops   <= 1'b0;
            r_alu_en     <= 1'b0;
            r_alu_op     <= '0;
            r_write_reg  <= 1'b0;
            r_write_nzcv <= 1'b0;
            r_halted     <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_wait     <= '0;
                    r_write_ir <= w_fetch_now;
                    r_write_pc <= w_fetch_now;
                end
                S_FETCH: begin
                    if (r_write_ir) begin
                        r_state    <= S_CHECK;
                        r_write_ir <= 1'b0;
                        r_write_pc <= 1'b0;
                    end else if (!w_armed) begin
                        if (w_go) begin
                            r_wait     <= '0;
                            r_write_ir <= w_fetch_now;
                            r_write_pc <= w_fetch_now;
                        end
                    end else begin
                        r_wait     <= r_wait + 4'd1;
                        r_write_ir <= ((r_wait + 4'd1) == WAIT_LAST);
                        r_write_pc <= ((r_wait + 4'd1) == WAIT_LAST);
                    end
                end
                S_CHECK: begin
                    if (w_ir_valid) begin
                        r_state <= S_DECODE;
                        if (w_cls == CLS_DP) begin
                            r_read_ops <= 1'b1;
                            r_alu_op   <= ir[24:21];
                        end
                    end else begin
                        r_state    <= S_FETCH;
                        r_wait     <= '0;
                        r_write_ir <= w_fetch_now;
                        r_write_pc <= w_fetch_now;
                    end
                end
                S_DECODE: begin
                    r_read_ops <= 1'b0;
                    if (w_cls == CLS_DP) begin
                        r_state  <= S_EXEC;
                        r_alu_en <= 1'b1;
                    end else if (w_cls == CLS_HALT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        // Unsupported class retires as a NOP
                        r_illegal  <= 1'b1;
                        r_state    <= S_FETCH;
                        r_wait     <= '0;
                        r_write_ir <= w_fetch_now;
                        r_write_pc <= w_fetch_now;
                    end
                end
                S_EXEC: begin
                    r_alu_en     <= 1'b0;
                    r_state      <= S_WB;
                    r_write_reg  <= !is_cmp_op(r_alu_op);
                    r_write_nzcv <= ir[20] || is_cmp_op(r_alu_op);
                end
                S_WB: begin
                    r_write_reg  <= 1'b0;
                    r_write_nzcv <= 1'b0;
                    r_state      <= S_FETCH;
                    r_wait       <= '0;
                    r_write_ir   <= w_fetch_now;
                    r_write_pc   <= w_fetch_now;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_ret_inc = (r_state == S_WB) || ((r_state == S_DECODE) && w_cls_bad);
    assign w_skp_inc = (r_state == S_CHECK) && !w_ir_valid;

    sat_counter #(
        .W (CNT_W)
    ) u_retired (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_ret_inc),
        .count (retired)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_skipped (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_skp_inc),
        .count (skipped)
    );

    assign write_pc   = r_write_pc;
    assign write_ir   = r_write_ir;
    assign read_ops   = r_read_ops;
    assign alu_en     = r_alu_en;
    assign alu_op     = r_alu_op;
    assign write_reg  = r_write_reg;
    assign write_nzcv = r_write_nzcv;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: two DUTs (FETCH_WAIT=0/CNT_W=16 and FETCH_WAIT=3/CNT_W=2).
// The driver plays the fetch unit and schedules expected strobe events per
// instruction; the monitor pops and compares them every cycle.
module tb_multicycle_ctrl;

    localparam int FW0 = 0;
    localparam int FW1 = 3;

    typedef struct {
        int         cyc;
        logic [5:0] stb;      // {write_pc, write_ir, read_ops, alu_en, write_reg, write_nzcv}
        logic [3:0] op;
        bit         chk_op;
        bit         is_fetch;
        int         ret;
        int         skp;
        bit         il;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2] = '{1'b1, 1'b1};
    logic [31:0] ir   [2] = '{32'h0, 32'h0};
    logic        vld  [2] = '{1'b0, 1'b0};
    logic        wpc [2], wir [2], rops [2], alue [2], wreg [2], wnzcv [2];
    logic        halted [2], illegal [2];
    logic [3:0]  aluop [2];
    logic [15:0] ret0, skp0;
    logic [1:0]  ret1, skp1;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    ev_t exp_q [2][$];

    int  nxt_fetch [2] = '{3 + FW0, 3 + FW1};
    int  rst_at [2] = '{-1, -1};
    int  rel_at [2] = '{2, 2};
    int  halt_from [2] = '{0, 0};
    int  halt_until [2] = '{0, 0};
    int  mret [2] = '{0, 0};
    int  mskp [2] = '{0, 0};
    bit  mil [2] = '{1'b0, 1'b0};
    int  pi [2] = '{0, 0};
    bit  started = 1'b0;

    multicycle_ctrl #(.FETCH_WAIT(FW0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst[0]), .ir(ir[0]), .w_ir_valid(vld[0]),
        .write_pc(wpc[0]), .write_ir(wir[0]), .read_ops(rops[0]), .alu_en(alue[0]),
        .alu_op(aluop[0]), .write_reg(wreg[0]), .write_nzcv(wnzcv[0]),
        .halted(halted[0]), .illegal(illegal[0]), .retired(ret0), .skipped(skp0)
    );

    multicycle_ctrl #(.FETCH_WAIT(FW1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst[1]), .ir(ir[1]), .w_ir_valid(vld[1]),
        .write_pc(wpc[1]), .write_ir(wir[1]), .read_ops(rops[1]), .alu_en(alue[1]),
        .alu_op(aluop[1]), .write_reg(wreg[1]), .write_nzcv(wnzcv[1]),
        .halted(halted[1]), .illegal(illegal[1]), .retired(ret1), .skipped(skp1)
    );

    function automatic int sat(input int d, input int x);
        int mx;
        mx = (d == 0) ? 65535 : 3;
        return (x < mx) ? x + 1 : x;
    endfunction

    task automatic check(input int d, input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, req);
        end
    endtask

    task automatic push(input int d, input int c, input logic [5:0] stb, input logic [3:0] op,
                        input bit chk_op, input bit is_fetch);
        ev_t e;
        e.cyc = c; e.stb = stb; e.op = op; e.chk_op = chk_op; e.is_fetch = is_fetch;
        e.ret = mret[d]; e.skp = mskp[d]; e.il = mil[d];
        exp_q[d].push_back(e);
    endtask

    // Directed prefix, then random instructions
    task automatic next_instr(input int d, input int idx, output logic [31:0] i, output logic v);
        int r;
        if (d == 0 && idx < 6) begin
            case (idx)
                0:       begin i = 32'hE0810002; v = 1'b1; end  // ADD
                1:       begin i = 32'hE1500001; v = 1'b1; end  // CMP
                2:       begin i = 32'hE0910002; v = 1'b1; end  // ADDS
                3:       begin i = 32'hE0810002; v = 1'b0; end  // condition fails
                4:       begin i = 32'hE4000000; v = 1'b1; end  // class 01
                default: begin i = 32'hEC000000; v = 1'b1; end  // halt
            endcase
        end else if (d == 1 && idx < 6) begin
            i = 32'hE0810002;
            v = (idx == 5);                                       // saturate skipped first
        end else begin
            r = $urandom_range(0, 15);
            i = $urandom;
            v = ($urandom_range(0, 3) != 0);
            if (r == 0)      i[27:26] = 2'b11;
            else if (r == 1) i[27:26] = 2'b01;
            else if (r == 2) i[27:26] = 2'b10;
            else             i[27:26] = 2'b00;
        end
    endtask

    // Fetch unit: load IR on the strobe and schedule the expected response
    task automatic issue(input int d);
        logic [31:0] i;
        logic        v;
        logic [3:0]  op;
        int          k, nf, fw;
        bit          cmp;
        fw = (d == 0) ? FW0 : FW1;
        next_instr(d, pi[d], i, v);
        pi[d]++;
        ir[d]  = i;
        vld[d] = v;
        k = cyc;
        if (!v) begin
            mskp[d] = sat(d, mskp[d]);
            nf = k + 2 + fw;
        end else if (i[27:26] == 2'b00) begin
            op  = i[24:21];
            cmp = (op >= 4'd8) && (op <= 4'd11);
            push(d, k + 2, 6'b001000, op, 1'b1, 1'b0);
            if (pi[d] > 8 && $urandom_range(0, 9) == 0) begin
                // reset lands in the ALU cycle
                rst_at[d] = k + 3; rel_at[d] = k + 5;
                mret[d] = 0; mskp[d] = 0; mil[d] = 1'b0;
                nf = k + 6 + fw;
            end else begin
                push(d, k + 3, 6'b000100, op, 1'b1, 1'b0);
                push(d, k + 4, {4'b0000, !cmp, i[20] | cmp}, op, 1'b1, 1'b0);
                mret[d] = sat(d, mret[d]);
                nf = k + 5 + fw;
            end
        end else if (i[27:26] == 2'b11) begin
            halt_from[d] = k + 3; halt_until[d] = k + 12;
            rst_at[d] = k + 12; rel_at[d] = k + 14;
            mret[d] = 0; mskp[d] = 0; mil[d] = 1'b0;
            nf = k + 15 + fw;
        end else begin
            mret[d] = sat(d, mret[d]);
            mil[d]  = 1'b1;
            nf = k + 3 + fw;
        end
        push(d, nf, 6'b110000, 4'h0, 1'b0, 1'b1);
        nxt_fetch[d] = nf;
    endtask

    task automatic monitor(input int d);
        logic [5:0] obs;
        ev_t        e;
        int         r, s;
        bit         exp_halt;
        obs = {wpc[d], wir[d], rops[d], alue[d], wreg[d], wnzcv[d]};
        r = (d == 0) ? int'(ret0) : int'(ret1);
        s = (d == 0) ? int'(skp0) : int'(skp1);
        while (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
            e = exp_q[d].pop_front();
            check(d, "missing_event", 64'(e.cyc), 64'(cyc));
        end
        if (rst[d]) begin
            check(d, "reset_state", 64'({obs, halted[d], illegal[d], (r != 0), (s != 0)}), 64'(0));
        end else begin
            exp_halt = (cyc >= halt_from[d]) && (cyc < halt_until[d]);
            check(d, "halted", 64'(halted[d]), 64'(exp_halt));
            if (exp_q[d].size() > 0 && exp_q[d][0].cyc == cyc) begin
                e = exp_q[d].pop_front();
                check(d, "strobes", 64'(obs), 64'(e.stb));
                if (e.chk_op) check(d, "alu_op", 64'(aluop[d]), 64'(e.op));
                if (e.is_fetch) begin
                    check(d, "retired", 64'(r), 64'(e.ret));
                    check(d, "skipped", 64'(s), 64'(e.skp));
                    check(d, "illegal", 64'(illegal[d]), 64'(e.il));
                end
            end else begin
                check(d, "idle_strobes", 64'(obs), 64'(0));
            end
        end
    endtask

    // Cycle count and reset scheduling, applied mid-cycle
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        for (int d = 0; d < 2; d++) begin
            if (cyc == rst_at[d]) rst[d] = 1'b1;
            if (cyc == rel_at[d]) rst[d] = 1'b0;
        end
    end

    // Stimulus / fetch-unit side
    always @(negedge clk) begin
        if (!started) begin
            started = 1'b1;
            for (int d = 0; d < 2; d++) push(d, nxt_fetch[d], 6'b110000, 4'h0, 1'b0, 1'b1);
        end
        for (int d = 0; d < 2; d++) begin
            if (!rst[d] && wir[d] && cyc == nxt_fetch[d]) issue(d);
        end
    end

    // Checking side
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitor(d);
    end

    initial begin
        repeat (4000) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
